ieee_sd_arbiter: RTL and testbench
==================================

Name: ieee_sd_arbiter

Overview:
- Sits downstream of the IEEE drive complex: consumes the per-block-device SD request arrays (lba, blk_cnt, rd, wr, buff_din) from all drive subunits.
- Serialises those requests onto a single host SD channel (one lba/rd/wr/ack port).
- Fair round-robin arbitration; acknowledge routed only to the granted device.
- Watchdog recovers from a host that never acknowledges.

Parameters:
- NBD, 2, number of block devices (1..8).
- TIMEOUT, 2**24, clk_sys cycles allowed between host request assertion and host sd_ack rising.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dev_lba  in  32 x NBD  per-device sector LBA
- dev_blk_cnt  in  6 x NBD  per-device block count minus one
- dev_rd  in  NBD  per-device read request (level)
- dev_wr  in  NBD  per-device write request (level)
- dev_ack  out  NBD  per-device acknowledge
- dev_buff_din  in  8 x NBD  per-device write data toward host
- sd_lba  out  32  host LBA
- sd_blk_cnt  out  6  host block count
- sd_rd  out  1  host read request
- sd_wr  out  1  host write request
- sd_ack  in  1  host acknowledge (high for whole transfer)
- sd_buff_din  out  8  write data muxed from granted device
- grant  out  3  index of current/last granted device
- busy  out  1  transaction in progress
- timeout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, sd_blk_cnt=0, dev_ack=0, grant=0, busy=0, timeout_err=0, RR pointer=0, state=DRAIN.
- States:
  - DRAIN: wait until sd_ack=0, then go to IDLE. Entered from reset, so a transfer left running in the host is not misattributed.
  - IDLE: compute pending[i] = dev_rd[i] | dev_wr[i]. If any pending, select the first pending index at or after ptr, wrapping modulo NBD. Latch grant, lba, blk_cnt and op (wr wins if dev_rd and dev_wr are both set). Go to ISSUE. busy=1 from this edge.
  - ISSUE: sd_rd or sd_wr registered high; first asserted on the cycle after the request is sampled in IDLE (1-cycle latency). Watchdog counts up. When sd_ack=1: drop sd_rd/sd_wr on the next edge and go to XFER. If the watchdog reaches TIMEOUT-1: drop the request, pulse timeout_err, set ptr=grant+1 and go to DRAIN.
  - XFER: hold until sd_ack=0, then go to DONE.
  - DONE: one cycle. ptr = grant+1 (wrap to 0 at NBD), busy=0, go to IDLE.
- dev_ack[i] = sd_ack AND (state in {ISSUE, XFER}) AND (grant==i). This is combinational, so the ack stays aligned with the host's sd_buff_wr / sd_buff_addr, which are broadcast to devices outside this block.
- sd_buff_din = dev_buff_din[grant]. Combinational mux, valid while busy.
- sd_lba and sd_blk_cnt come from the latched values and are stable from ISSUE through DONE. A device changing dev_lba mid-transaction has no effect.
- Devices must drop rd/wr on seeing dev_ack. A request still high when IDLE is re-entered counts as a new request and is re-issued.
- Devices not granted see dev_ack=0. Their requests stay pending and are never lost.
- A request deasserted before grant is ignored.
- Simultaneous requests are served in RR order starting at ptr. No device waits more than NBD-1 transactions.
- reset asserted in any state takes priority and gives the reset values on the next edge.

Decomposition:
- Shared package ieeedrv_pkg holds:
  - enum t_sdarb_state {DRAIN, IDLE, ISSUE, XFER, DONE}
  - localparam SDARB_MAX_DEV=8
  - typedef t_sd_req {lba[31:0], blk_cnt[5:0], wr} for the latched request
- One sub-module, ieee_rr_pick: combinational, inputs pending[NBD] and ptr, outputs valid and index. Instantiated once.

Test Plan:
1. NBD=2. dev_rd[0]=1, lba=0x1234, blk_cnt=0. Host raises sd_ack 3 cycles after sd_rd and holds it 10 cycles → sd_rd high exactly 1 cycle after sampling; sd_lba=0x1234; dev_ack[0] mirrors sd_ack for 10 cycles; dev_ack[1]=0; busy drops one cycle after sd_ack falls.
2. dev_rd[0], dev_rd[1] and dev_wr[1] all raised in the same cycle, ptr=0 → device 0 served first. Device 1 served next with sd_wr=1 and sd_rd=0; ptr=0 afterwards; sd_buff_din tracks dev_buff_din[1] during the second transfer.
3. Device 1 keeps dev_rd high after its ack → it is re-issued immediately after DONE. Device 0 raising its request during that re-issue is served next, showing no starvation.
4. TIMEOUT=16, host never acks → sd_rd drops after 16 cycles in ISSUE; timeout_err pulses once; arbiter returns to IDLE and grants the next pending device.
5. Assert reset during XFER while sd_ack is still high → all outputs at reset values the next cycle. New requests are not issued until sd_ack falls, then device 0 is granted.
6. dev_lba[0] changed from 0x10 to 0x20 during ISSUE → sd_lba stays 0x10 until DONE.

Source files
------------

// File: rtl/ieeedrv_pkg.sv
// Shared types for the IEEE drive complex SD arbitration path.
package ieeedrv_pkg;

    localparam int unsigned SDARB_MAX_DEV = 8;

    typedef enum logic [2:0] {
        DRAIN,
        IDLE,
        ISSUE,
        XFER,
        DONE
    } t_sdarb_state;

    // Request captured at grant time; the host sees only this copy.
    typedef struct packed {
        logic [31:0] lba;
        logic [5:0]  blk_cnt;
        logic        wr;
    } t_sd_req;

    // Device index following idx, wrapping to 0 at nbd.
    function automatic logic [2:0] sdarb_next_idx(input logic [2:0] idx, input int unsigned nbd);
        logic [3:0] inc;
        inc = {1'b0, idx} + 4'd1;
        if (32'(inc) >= nbd) begin
            return 3'd0;
        end
        return inc[2:0];
    endfunction

endpackage

// File: rtl/ieee_rr_pick.sv
// Round-robin pick: first pending device at or after ptr, wrapping modulo NBD.
module ieee_rr_pick
    import ieeedrv_pkg::*;
#(
    parameter int unsigned NBD = 2
) (
    input  logic [NBD-1:0] pending,
    input  logic [2:0]     ptr,
    output logic           valid,
    output logic [2:0]     index
);

    logic [SDARB_MAX_DEV-1:0] pend_ext;

    // Walk NBD slots starting at ptr and keep the first pending one.
    always_comb begin
        logic [2:0] idx;
        pend_ext          = '0;
        pend_ext[NBD-1:0] = pending;
        valid             = 1'b0;
        index             = 3'd0;
        idx               = ptr;
        for (int unsigned k = 0; k < NBD; k++) begin
            if (!valid && pend_ext[idx]) begin
                valid = 1'b1;
                index = idx;
            end
            idx = sdarb_next_idx(idx, NBD);
        end
    end

endmodule

// File: rtl/ieee_sd_arbiter.sv
// Serialises per-device SD requests onto one host SD channel with round-robin
// fairness, ack routing to the granted device and a watchdog on the host ack.
module ieee_sd_arbiter
    import ieeedrv_pkg::*;
#(
    parameter int unsigned NBD     = 2,
    parameter int unsigned TIMEOUT = 2**24
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [NBD-1:0][31:0] dev_lba,
    input  logic [NBD-1:0][5:0]  dev_blk_cnt,
    input  logic [NBD-1:0]       dev_rd,
    input  logic [NBD-1:0]       dev_wr,
    output logic [NBD-1:0]       dev_ack,
    input  logic [NBD-1:0][7:0]  dev_buff_din,
    output logic [31:0]          sd_lba,
    output logic [5:0]           sd_blk_cnt,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    output logic [7:0]           sd_buff_din,
    output logic [2:0]           grant,
    output logic                 busy,
    output logic                 timeout_err
);

    t_sdarb_state state_q, state_d;
    t_sd_req      req_q, req_d;
    t_sd_req      pick_req;
    logic [2:0]   ptr_q, ptr_d;
    logic [2:0]   grant_q, grant_d;
    logic         issue_q, issue_d;
    logic         busy_q, busy_d;
    logic         tmo_q, tmo_d;
    logic [31:0]  wd_q, wd_d;
    logic         pick_valid;
    logic [2:0]   pick_idx;
    logic [7:0]   buff_mux;
    logic         ack_window;

    ieee_rr_pick #(
        .NBD (NBD)
    ) u_rr_pick (
        .pending (dev_rd | dev_wr),
        .ptr     (ptr_q),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    assign ack_window = (state_q == ISSUE) || (state_q == XFER);

    // Per-device muxing: request capture for the pick, write data and ack for the grant.
    always_comb begin
        pick_req = '0;
        buff_mux = '0;
        dev_ack  = '0;
        for (int unsigned i = 0; i < NBD; i++) begin
            if (pick_idx == 3'(i)) begin
                pick_req.lba     = dev_lba[i];
                pick_req.blk_cnt = dev_blk_cnt[i];
                pick_req.wr      = dev_wr[i];
            end
            if (grant_q == 3'(i)) begin
                buff_mux = dev_buff_din[i];
            end
            dev_ack[i] = sd_ack && ack_window && (grant_q == 3'(i));
        end
    end

    // Next-state logic for the arbitration FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        issue_d = issue_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        wd_d    = wd_q;
        unique case (state_q)
            DRAIN: begin
                // Never attribute a transfer still running in the host to a new grant.
                if (!sd_ack) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    req_d   = pick_req;
                    issue_d = 1'b1;
                    busy_d  = 1'b1;
                    wd_d    = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    issue_d = 1'b0;
                    state_d = XFER;
                end else if (wd_q == 32'(TIMEOUT - 1)) begin
                    issue_d = 1'b0;
                    busy_d  = 1'b0;
                    tmo_d   = 1'b1;
                    ptr_d   = sdarb_next_idx(grant_q, NBD);
                    state_d = DRAIN;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = sdarb_next_idx(grant_q, NBD);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = DRAIN;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= DRAIN;
            req_q   <= '0;
            ptr_q   <= 3'd0;
            grant_q <= 3'd0;
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            issue_q <= issue_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            wd_q    <= wd_d;
        end
    end

    assign sd_lba      = req_q.lba;
    assign sd_blk_cnt  = req_q.blk_cnt;
    assign sd_rd       = issue_q && !req_q.wr;
    assign sd_wr       = issue_q && req_q.wr;
    assign sd_buff_din = buff_mux;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ieee_sd_arbiter.sv
// Self-checking bench for ieee_sd_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_ieee_sd_arbiter;

    localparam int NBD     = 2;
    localparam int TIMEOUT = 16;
    localparam int MAXWAIT = 50;

    logic                 clk_sys = 1'b0;
    logic                 reset;
    logic [NBD-1:0][31:0] dev_lba;
    logic [NBD-1:0][5:0]  dev_blk_cnt;
    logic [NBD-1:0]       dev_rd;
    logic [NBD-1:0]       dev_wr;
    logic [NBD-1:0]       dev_ack;
    logic [NBD-1:0][7:0]  dev_buff_din;
    logic [31:0]          sd_lba;
    logic [5:0]           sd_blk_cnt;
    logic                 sd_rd;
    logic                 sd_wr;
    logic                 sd_ack;
    logic [7:0]           sd_buff_din;
    logic [2:0]           grant;
    logic                 busy;
    logic                 timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr_m   = 0;  // model round-robin pointer

    ieee_sd_arbiter #(
        .NBD     (NBD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .dev_lba      (dev_lba),
        .dev_blk_cnt  (dev_blk_cnt),
        .dev_rd       (dev_rd),
        .dev_wr       (dev_wr),
        .dev_ack      (dev_ack),
        .dev_buff_din (dev_buff_din),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .grant        (grant),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sd_rd"},       64'(sd_rd),       64'(0));
        check({tag, "_sd_wr"},       64'(sd_wr),       64'(0));
        check({tag, "_sd_lba"},      64'(sd_lba),      64'(0));
        check({tag, "_sd_blk_cnt"},  64'(sd_blk_cnt),  64'(0));
        check({tag, "_dev_ack"},     64'(dev_ack),     64'(0));
        check({tag, "_grant"},       64'(grant),       64'(0));
        check({tag, "_busy"},        64'(busy),        64'(0));
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        sd_ack = 1'b0;
        dev_rd = '0;
        dev_wr = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();  // leave DRAIN
        ptr_m = 0;
    endtask

    // Acts as the host for one transaction and checks it against the model.
    task automatic serve(input bit no_ack, input int ack_delay, input int hold, input bit keep_req,
                         input bit poke, input logic [31:0] poke_val, input int raise_other,
                         output int lat);
        int          exp_dev;
        int          d;
        int          cyc;
        bit          exp_wr;
        logic [31:0] exp_lba;
        logic [5:0]  exp_cnt;

        exp_dev = -1;
        for (int k = 0; k < NBD; k++) begin
            d = (ptr_m + k) % NBD;
            if (exp_dev < 0 && (dev_rd[d] || dev_wr[d])) exp_dev = d;
        end
        if (exp_dev < 0) exp_dev = 0;
        exp_wr  = dev_wr[exp_dev];
        exp_lba = dev_lba[exp_dev];
        exp_cnt = dev_blk_cnt[exp_dev];

        lat = 0;
        while (!(sd_rd || sd_wr) && lat < MAXWAIT) begin
            tick();
            lat++;
        end
        check("req_raised", 64'(sd_rd | sd_wr), 64'(1));
        check("grant",      64'(grant),         64'(exp_dev));
        check("sd_wr",      64'(sd_wr),         64'(exp_wr));
        check("sd_rd",      64'(sd_rd),         64'(!exp_wr));
        check("sd_lba",     64'(sd_lba),        64'(exp_lba));
        check("sd_blk_cnt", 64'(sd_blk_cnt),    64'(exp_cnt));
        check("busy_issue", 64'(busy),          64'(1));
        if (poke) dev_lba[exp_dev] = poke_val;

        if (no_ack) begin
            cyc = 1;
            while ((sd_rd || sd_wr) && cyc < TIMEOUT + 8) begin
                check("no_early_timeout", 64'(timeout_err), 64'(0));
                tick();
                if (sd_rd || sd_wr) cyc++;
            end
            check("timeout_len",        64'(cyc),         64'(TIMEOUT));
            check("timeout_err_pulse",  64'(timeout_err), 64'(1));
            check("busy_after_timeout", 64'(busy),        64'(0));
            tick();
            check("timeout_err_single", 64'(timeout_err), 64'(0));
            ptr_m = (exp_dev + 1) % NBD;
        end else begin
            for (int i = 0; i < ack_delay; i++) begin
                tick();
                check("req_held", 64'(sd_rd | sd_wr), 64'(1));
                check("ack_idle", 64'(dev_ack),       64'(0));
            end
            sd_ack = 1'b1;
            for (int h = 0; h < hold; h++) begin
                for (int j = 0; j < NBD; j++) dev_buff_din[j] = 8'($urandom);
                if (h == 0) begin
                    if (!keep_req) begin
                        dev_rd[exp_dev] = 1'b0;
                        dev_wr[exp_dev] = 1'b0;
                    end
                    if (raise_other >= 0) dev_rd[raise_other] = 1'b1;
                end
                #1;
                check("dev_ack_routed", 64'(dev_ack),     64'(1 << exp_dev));
                check("buff_din_mux",   64'(sd_buff_din), 64'(dev_buff_din[exp_dev]));
                check("lba_stable",     64'(sd_lba),      64'(exp_lba));
                tick();
                check("req_dropped",    64'(sd_rd | sd_wr), 64'(0));
            end
            sd_ack = 1'b0;
            #1;
            check("dev_ack_off", 64'(dev_ack), 64'(0));
            tick();
            check("busy_done",       64'(busy),   64'(1));
            check("lba_stable_done", 64'(sd_lba), 64'(exp_lba));
            tick();
            check("busy_release", 64'(busy), 64'(0));
            ptr_m = (exp_dev + 1) % NBD;
        end
    endtask

    initial begin
        int lat;
        int d;

        reset        = 1'b1;
        sd_ack       = 1'b0;
        dev_rd       = '0;
        dev_wr       = '0;
        dev_lba      = '0;
        dev_blk_cnt  = '0;
        dev_buff_din = '0;
        tick();
        check_reset_vals("rst");
        do_reset();
        check_reset_vals("post_rst");

        // Single read, host acks 3 cycles late and holds for 10.
        dev_lba[0]     = 32'h1234;
        dev_blk_cnt[0] = 6'd0;
        dev_rd[0]      = 1'b1;
        check("no_req_before_sample", 64'(sd_rd), 64'(0));
        serve(1'b0, 3, 10, 1'b0, 1'b0, 32'h0, -1, lat);
        check("issue_latency", 64'(lat), 64'(1));

        // Simultaneous requests from ptr 0; wr wins on device 1.
        do_reset();
        dev_lba[0] = 32'hA000_0000;
        dev_lba[1] = 32'hB000_0001;
        dev_rd     = 2'b11;
        dev_wr     = 2'b10;
        serve(1'b0, 1, 3, 1'b0, 1'b0, 32'h0, -1, lat);
        serve(1'b0, 2, 5, 1'b0, 1'b0, 32'h0, -1, lat);

        // Device 1 holds its request: re-issued at once; device 0 then served.
        dev_rd[1] = 1'b1;
        serve(1'b0, 0, 2, 1'b1, 1'b0, 32'h0, -1, lat);
        serve(1'b0, 1, 3, 1'b0, 1'b0, 32'h0, 0, lat);
        check("reissue_latency", 64'(lat), 64'(1));
        serve(1'b0, 0, 2, 1'b0, 1'b0, 32'h0, -1, lat);

        // Host never acks: watchdog fires, next pending device granted.
        dev_rd = 2'b11;
        serve(1'b1, 0, 0, 1'b0, 1'b0, 32'h0, -1, lat);
        serve(1'b0, 0, 2, 1'b0, 1'b0, 32'h0, -1, lat);
        serve(1'b0, 0, 2, 1'b0, 1'b0, 32'h0, -1, lat);

        // Reset during XFER with the host ack still high.
        dev_rd[1] = 1'b1;
        lat = 0;
        while (!sd_rd && lat < MAXWAIT) begin
            tick();
            lat++;
        end
        check("xfer_req_seen", 64'(sd_rd), 64'(1));
        sd_ack = 1'b1;
        tick();
        tick();
        dev_rd[1] = 1'b0;
        reset     = 1'b1;
        tick();
        check_reset_vals("xfer_rst");
        reset      = 1'b0;
        dev_lba[0] = 32'h5555_0000;
        dev_rd[0]  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_no_issue", 64'(sd_rd | sd_wr), 64'(0));
            check("drain_not_busy", 64'(busy),          64'(0));
        end
        sd_ack = 1'b0;
        ptr_m  = 0;
        serve(1'b0, 1, 2, 1'b0, 1'b0, 32'h0, -1, lat);

        // LBA changed mid-ISSUE must not reach the host.
        dev_lba[0] = 32'h10;
        dev_rd[0]  = 1'b1;
        serve(1'b0, 2, 3, 1'b0, 1'b1, 32'h20, -1, lat);

        // Randomized traffic against the round-robin model.
        for (int it = 0; it < 150; it++) begin
            for (int j = 0; j < NBD; j++) begin
                if (!(dev_rd[j] || dev_wr[j]) && $urandom_range(1, 0) == 1) begin
                    dev_lba[j]     = $urandom;
                    dev_blk_cnt[j] = 6'($urandom);
                    case ($urandom_range(2, 0))
                        0:       dev_rd[j] = 1'b1;
                        1:       dev_wr[j] = 1'b1;
                        default: begin
                            dev_rd[j] = 1'b1;
                            dev_wr[j] = 1'b1;
                        end
                    endcase
                end else if ((dev_rd[j] || dev_wr[j]) && $urandom_range(7, 0) == 0) begin
                    // Withdrawn before the arbiter samples it.
                    dev_rd[j] = 1'b0;
                    dev_wr[j] = 1'b0;
                end
            end
            if (dev_rd == '0 && dev_wr == '0) begin
                d         = int'($urandom_range(NBD - 1, 0));
                dev_rd[d] = 1'b1;
            end
            serve($urandom_range(11, 0) == 0, int'($urandom_range(4, 0)),
                  int'($urandom_range(6, 1)), $urandom_range(3, 0) == 0,
                  $urandom_range(2, 0) == 0, $urandom, -1, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
